// File: rtl/axi4_lite_cmd_sequencer_pkg.sv
// Shared AXI4-Lite definitions: bus widths, command record and sequencer states.
package axi4_lite_Defs;

  localparam int Addr_Width = 32;
  localparam int Data_Width = 32;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic                  write;
    logic [Addr_Width-1:0] addr;
    logic [Data_Width-1:0] data;
  } axi4_cmd_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_WAIT,
    SEQ_RESP
  } seq_state_t;

endpackage

// File: rtl/axi4_lite_cmd_sequencer_fifo.sv
// Synchronous command FIFO with registered full/empty flags and occupancy count.
module axi4_cmd_fifo
  import axi4_lite_Defs::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  axi4_cmd_t              i_data,
  input  logic                   i_pop,
  output axi4_cmd_t              o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  axi4_cmd_t     r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic [PW:0]   w_count_nxt;
  logic          r_full;
  logic          r_empty;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Flags come from the next count, so a pop only frees a slot for the following cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (PW+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/axi4_lite_cmd_sequencer.sv
// Queues host read/write commands and issues them one at a time to axi4_lite_master,
// returning one response (or a forced timeout response) per command.
module axi4_lite_cmd_sequencer
  import axi4_lite_Defs::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [Addr_Width-1:0]  cmd_addr,
  input  logic [Data_Width-1:0]  cmd_wdata,
  output logic                   rd_en,
  output logic                   wr_en,
  output logic [Addr_Width-1:0]  Read_Address,
  output logic [Addr_Width-1:0]  Write_Address,
  output logic [Data_Width-1:0]  Write_Data,
  input  logic                   wr_done,
  input  logic [1:0]             bresp,
  input  logic                   rd_done,
  input  logic [Data_Width-1:0]  rdata,
  input  logic [1:0]             rresp,
  output logic                   rsp_valid,
  output logic                   rsp_write,
  output logic [Data_Width-1:0]  rsp_data,
  output logic [1:0]             rsp_resp,
  output logic                   rsp_timeout,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);

  seq_state_t            r_state;
  seq_state_t            w_state_nxt;
  axi4_cmd_t             w_cmd_in;
  axi4_cmd_t             w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_done_match;
  logic                  w_timeout;
  logic                  r_cmd_write;
  logic [Addr_Width-1:0] r_rd_addr;
  logic [Addr_Width-1:0] r_wr_addr;
  logic [Data_Width-1:0] r_wr_data;
  logic [CW-1:0]         r_cnt;
  logic                  r_rsp_write;
  logic [Data_Width-1:0] r_rsp_data;
  logic [1:0]            r_rsp_resp;
  logic                  r_rsp_timeout;

  assign w_cmd_in.write = cmd_write;
  assign w_cmd_in.addr  = cmd_addr;
  assign w_cmd_in.data  = cmd_wdata;

  axi4_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_push  (cmd_valid),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (q_count)
  );

  assign cmd_ready    = !w_full;
  assign w_done_match = r_cmd_write ? wr_done : rd_done;
  // WAIT starts at count 0; RESP is entered on the edge the count would reach TIMEOUT_CYC-1.
  assign w_timeout    = (r_cnt == CW'(TIMEOUT_CYC - 2));

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= SEQ_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SEQ_IDLE:  if (!w_empty) w_state_nxt = SEQ_ISSUE;
      SEQ_ISSUE: w_state_nxt = SEQ_WAIT;
      SEQ_WAIT:  if (w_done_match || w_timeout) w_state_nxt = SEQ_RESP;
      SEQ_RESP:  w_state_nxt = SEQ_IDLE;
      default:   w_state_nxt = SEQ_IDLE;
    endcase
  end

  always_comb begin
    w_pop     = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    rsp_valid = 1'b0;
    unique case (r_state)
      SEQ_IDLE:  w_pop = !w_empty;
      SEQ_ISSUE: begin
        wr_en = r_cmd_write;
        rd_en = !r_cmd_write;
      end
      SEQ_RESP:  rsp_valid = 1'b1;
      default:   w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cmd_write <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_pop) begin
        r_cmd_write <= w_head.write;
        if (w_head.write) begin
          r_wr_addr <= w_head.addr;
          r_wr_data <= w_head.data;
        end else begin
          r_rd_addr <= w_head.addr;
        end
      end
      if (r_state == SEQ_ISSUE)     r_cnt <= '0;
      else if (r_state == SEQ_WAIT) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Response fields are only non-zero during the RESP cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET || r_state == SEQ_RESP) begin
      r_rsp_write   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_resp    <= '0;
      r_rsp_timeout <= 1'b0;
    end else if (r_state == SEQ_WAIT && w_done_match) begin
      r_rsp_write   <= r_cmd_write;
      r_rsp_data    <= r_cmd_write ? '0 : rdata;
      r_rsp_resp    <= r_cmd_write ? bresp : rresp;
      r_rsp_timeout <= 1'b0;
    end else if (r_state == SEQ_WAIT && w_timeout) begin
      r_rsp_write   <= r_cmd_write;
      r_rsp_data    <= '0;
      r_rsp_resp    <= RESP_SLVERR;
      r_rsp_timeout <= 1'b1;
    end
  end

  assign Read_Address  = r_rd_addr;
  assign Write_Address = r_wr_addr;
  assign Write_Data    = r_wr_data;
  assign rsp_write     = r_rsp_write;
  assign rsp_data      = r_rsp_data;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_timeout   = r_rsp_timeout;

endmodule

// File: tb/tb_axi4_lite_cmd_sequencer.sv
// Directed bench for axi4_lite_cmd_sequencer; drives and samples on the falling clock edge.
module tb_axi4_lite_cmd_sequencer;
  import axi4_lite_Defs::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;
  localparam int          BOUND = 64;

  logic                   ACLK = 1'b0;
  logic                   ARESET;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [Addr_Width-1:0]  cmd_addr;
  logic [Data_Width-1:0]  cmd_wdata;
  logic                   rd_en;
  logic                   wr_en;
  logic [Addr_Width-1:0]  Read_Address;
  logic [Addr_Width-1:0]  Write_Address;
  logic [Data_Width-1:0]  Write_Data;
  logic                   wr_done;
  logic [1:0]             bresp;
  logic                   rd_done;
  logic [Data_Width-1:0]  rdata;
  logic [1:0]             rresp;
  logic                   rsp_valid;
  logic                   rsp_write;
  logic [Data_Width-1:0]  rsp_data;
  logic [1:0]             rsp_resp;
  logic                   rsp_timeout;
  logic [$clog2(DEPTH):0] q_count;

  axi4_lite_cmd_sequencer #(
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rd_en         (rd_en),
    .wr_en         (wr_en),
    .Read_Address  (Read_Address),
    .Write_Address (Write_Address),
    .Write_Data    (Write_Data),
    .wr_done       (wr_done),
    .bresp         (bresp),
    .rd_done       (rd_done),
    .rdata         (rdata),
    .rresp         (rresp),
    .rsp_valid     (rsp_valid),
    .rsp_write     (rsp_write),
    .rsp_data      (rsp_data),
    .rsp_resp      (rsp_resp),
    .rsp_timeout   (rsp_timeout),
    .q_count       (q_count)
  );

  always #5 ACLK = ~ACLK;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;
  int unsigned n_both = 0;
  int unsigned n_rd_during_wr = 0;
  int unsigned n_rsp  = 0;
  int unsigned n_en   = 0;
  logic        pend_wr = 1'b0;

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) begin
    if (rd_en && wr_en)   n_both++;
    if (rd_en && pend_wr) n_rd_during_wr++;
    if (rsp_valid)        n_rsp++;
    if (rd_en || wr_en)   n_en++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic w, input logic [Addr_Width-1:0] a, input logic [Data_Width-1:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < BOUND) begin
      @(negedge ACLK);
      n++;
    end
    check("push_ready", cmd_ready, 1);
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_en(input string tag, input logic w, input logic [Addr_Width-1:0] a,
                         input logic [Data_Width-1:0] d, output int unsigned c);
    int n = 0;
    while (!(rd_en || wr_en) && n < BOUND) begin
      @(negedge ACLK);
      n++;
    end
    c = cyc;
    check({tag, "_wr_en"}, wr_en, w);
    check({tag, "_rd_en"}, rd_en, !w);
    if (w) begin
      check({tag, "_waddr"}, Write_Address, a);
      check({tag, "_wdata"}, Write_Data, d);
    end else begin
      check({tag, "_raddr"}, Read_Address, a);
    end
  endtask

  task automatic drive_wr_done(input logic [1:0] r);
    @(negedge ACLK);
    wr_done = 1'b1;
    bresp   = r;
    @(negedge ACLK);
    wr_done = 1'b0;
    bresp   = 2'b00;
  endtask

  task automatic drive_rd_done(input logic [Data_Width-1:0] d, input logic [1:0] r);
    @(negedge ACLK);
    rd_done = 1'b1;
    rdata   = d;
    rresp   = r;
    @(negedge ACLK);
    rd_done = 1'b0;
    rdata   = '0;
    rresp   = 2'b00;
  endtask

  task automatic expect_rsp(input string tag, input logic w, input logic [Data_Width-1:0] d,
                            input logic [1:0] r, input logic t);
    int n = 0;
    while (!rsp_valid && n < BOUND) begin
      @(negedge ACLK);
      n++;
    end
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_rsp_write"}, rsp_write, w);
    check({tag, "_rsp_data"}, rsp_data, d);
    check({tag, "_rsp_resp"}, rsp_resp, r);
    check({tag, "_rsp_timeout"}, rsp_timeout, t);
  endtask

  logic                  t3_w [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [Addr_Width-1:0] t3_a [5] = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h30};
  logic [Data_Width-1:0] t3_d [5] = '{32'hA0A0A0A0, 32'h0BADF00D, 32'h12345678, 32'h87654321, 32'hCAFEF00D};
  logic [1:0]            t3_r [5] = '{2'b00, 2'b00, 2'b11, 2'b01, 2'b00};

  initial begin
    int unsigned c0;
    int unsigned n;
    int unsigned rsp_before;
    int unsigned en_before;

    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    wr_done = 1'b0; bresp = 2'b00; rd_done = 1'b0; rdata = '0; rresp = 2'b00;
    repeat (3) @(negedge ACLK);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_q_count", q_count, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    ARESET = 1'b0;
    @(negedge ACLK);

    // 1: single write, latency and response
    push(1'b1, 32'h10, 32'hDEADBEEF);
    check("t1_q_count", q_count, 1);
    check("t1_early_wr_en", wr_en, 0);
    @(negedge ACLK);
    check("t1_wr_en", wr_en, 1);
    check("t1_rd_en", rd_en, 0);
    check("t1_waddr", Write_Address, 32'h10);
    check("t1_wdata", Write_Data, 32'hDEADBEEF);
    check("t1_q_popped", q_count, 0);
    @(negedge ACLK);
    check("t1_wr_en_single", wr_en, 0);
    wr_done = 1'b1; bresp = 2'b00;
    @(negedge ACLK);
    wr_done = 1'b0;
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_write", rsp_write, 1);
    check("t1_rsp_resp", rsp_resp, 0);
    check("t1_rsp_data", rsp_data, 0);
    check("t1_rsp_timeout", rsp_timeout, 0);
    @(negedge ACLK);
    check("t1_rsp_pulse", rsp_valid, 0);

    // 2: write then read of the same address
    push(1'b1, 32'h10, 32'hDEADBEEF);
    push(1'b0, 32'h10, 32'h0);
    wait_en("t2w", 1'b1, 32'h10, 32'hDEADBEEF, c0);
    pend_wr = 1'b1;
    repeat (3) @(negedge ACLK);
    drive_wr_done(2'b00);
    expect_rsp("t2w", 1'b1, 32'h0, 2'b00, 1'b0);
    pend_wr = 1'b0;
    wait_en("t2r", 1'b0, 32'h10, 32'h0, c0);
    drive_rd_done(32'hDEADBEEF, 2'b00);
    expect_rsp("t2r", 1'b0, 32'hDEADBEEF, 2'b00, 1'b0);
    check("t2_rd_during_wr", n_rd_during_wr, 0);

    // 3: fill the queue behind a stalled write
    push(1'b1, 32'h100, 32'h11111111);
    wait_en("t3s", 1'b1, 32'h100, 32'h11111111, c0);
    for (int i = 0; i < 4; i++) push(t3_w[i], t3_a[i], t3_d[i]);
    check("t3_ready_low", cmd_ready, 0);
    check("t3_q_full", q_count, 4);
    fork
      push(t3_w[4], t3_a[4], t3_d[4]);
      begin
        repeat (2) @(negedge ACLK);
        check("t3_held_q", q_count, 4);
        check("t3_held_ready", cmd_ready, 0);
        drive_wr_done(2'b00);
        expect_rsp("t3s", 1'b1, 32'h0, 2'b00, 1'b0);
        wait_en("t3_0", t3_w[0], t3_a[0], t3_d[0], c0);
      end
    join
    check("t3_q_after", q_count, 4);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) wait_en($sformatf("t3_%0d", i), t3_w[i], t3_a[i], t3_d[i], c0);
      if (t3_w[i]) drive_wr_done(t3_r[i]);
      else         drive_rd_done(t3_d[i], t3_r[i]);
      expect_rsp($sformatf("t3_%0d", i), t3_w[i], t3_w[i] ? 32'h0 : t3_d[i], t3_r[i], 1'b0);
    end

    // 4: read timeout, then the queued write proceeds
    push(1'b0, 32'h200, 32'h0);
    push(1'b1, 32'h204, 32'h55);
    wait_en("t4r", 1'b0, 32'h200, 32'h0, c0);
    n = 0;
    while (!rsp_valid && n < BOUND) begin
      @(negedge ACLK);
      n++;
    end
    check("t4_latency", cyc - c0, TMO);
    expect_rsp("t4r", 1'b0, 32'h0, 2'b10, 1'b1);
    wait_en("t4w", 1'b1, 32'h204, 32'h55, c0);
    drive_wr_done(2'b00);
    expect_rsp("t4w", 1'b1, 32'h0, 2'b00, 1'b0);

    // 5: read completion while a write is pending is ignored
    push(1'b1, 32'h300, 32'hA5A5A5A5);
    wait_en("t5", 1'b1, 32'h300, 32'hA5A5A5A5, c0);
    drive_rd_done(32'h1234, 2'b11);
    check("t5_no_rsp_a", rsp_valid, 0);
    @(negedge ACLK);
    check("t5_no_rsp_b", rsp_valid, 0);
    drive_wr_done(2'b01);
    expect_rsp("t5", 1'b1, 32'h0, 2'b01, 1'b0);

    // 6: reset while waiting with two commands queued
    push(1'b1, 32'h400, 32'h44444444);
    wait_en("t6", 1'b1, 32'h400, 32'h44444444, c0);
    push(1'b0, 32'h404, 32'h0);
    push(1'b1, 32'h408, 32'h88);
    check("t6_q_before", q_count, 2);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    check("t6_q_count", q_count, 0);
    check("t6_rd_en", rd_en, 0);
    check("t6_wr_en", wr_en, 0);
    check("t6_raddr", Read_Address, 0);
    check("t6_waddr", Write_Address, 0);
    check("t6_wdata", Write_Data, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_rsp_fields", {rsp_write, rsp_timeout, rsp_resp, rsp_data}, 0);
    rsp_before = n_rsp;
    en_before  = n_en;
    drive_wr_done(2'b00);
    repeat (4) @(negedge ACLK);
    check("t6_late_done_rsp", n_rsp - rsp_before, 0);
    check("t6_no_issue", n_en - en_before, 0);

    check("excl_enables", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
